// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Two-port arbiter in front of a single-ported memory. Requester 0 is the
// core and requester 1 is a DMA/debug master. One transaction runs at a time
// through a three-state FSM:
//   IDLE   -> pick a port, latch its request and enter ACCESS
//   ACCESS -> drive RD or WR for WAIT+1 cycles
//   DONE   -> pulse the granted port's ACK for one cycle, then return to IDLE
// When both ports request in the same IDLE cycle, the port that was not
// served last wins. This makes grants alternate under continuous contention.
//
// Parameters
//   WAIT            extra memory wait cycles per access (0..15)
//
// Ports
//   CLK             system clock, rising edge
//   RES             synchronous active-high reset
//   REQ0/REQ1       access request per port
//   WE0/WE1         request type per port (1 = write, 0 = read)
//   ADDR0/ADDR1     request address per port
//   WDATA0/WDATA1   write data per port
//   ACK0/ACK1       one-cycle completion strobe per port
//   RDATA0/RDATA1   read data per port, held until the next read on that port
//   RD/WR           memory read / write strobes
//   ADDR            memory address
//   DOUT            memory write data
//   DIN             memory read data
//   BUSY            high whenever the FSM is not in IDLE
//   GNT             index of the port owning the current transaction
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int unsigned WAIT = 1
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        WE0,
  input  logic        WE1,
  input  logic [15:0] ADDR0,
  input  logic [15:0] ADDR1,
  input  logic [15:0] WDATA0,
  input  logic [15:0] WDATA1,
  output logic        ACK0,
  output logic        ACK1,
  output logic [15:0] RDATA0,
  output logic [15:0] RDATA1,
  output logic        RD,
  output logic        WR,
  output logic [15:0] ADDR,
  output logic [15:0] DOUT,
  input  logic [15:0] DIN,
  output logic        BUSY,
  output logic        GNT
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic        last_reg;
  logic        gnt_reg;
  logic        we_reg;
  logic        rd_reg;
  logic        wr_reg;
  logic        busy_reg;
  logic [1:0]  ack_reg;
  logic [15:0] addr_reg;
  logic [15:0] dout_reg;

  // Per-port request bundles, indexed by port number.
  logic [1:0]  req_vec;
  logic [1:0]  we_vec;
  logic [15:0] addr_vec  [2];
  logic [15:0] wdata_vec [2];
  logic [15:0] rdata_vec [2];

  assign req_vec      = {REQ1, REQ0};
  assign we_vec       = {WE1, WE0};
  assign addr_vec[0]  = ADDR0;
  assign addr_vec[1]  = ADDR1;
  assign wdata_vec[0] = WDATA0;
  assign wdata_vec[1] = WDATA1;

  // -------------------------------------------------------------------------
  // Grant selection. A lone requester always wins; on a tie the port that
  // was not served last wins. LAST resets to 1 so port 0 wins the first tie.
  // -------------------------------------------------------------------------
  logic        grant_any;
  logic        grant_idx;
  logic        grant_we;
  logic [15:0] grant_addr;
  logic [15:0] grant_wdata;

  always_comb begin
    grant_any = |req_vec;
    if (&req_vec) begin
      grant_idx = ~last_reg;
    end else begin
      grant_idx = req_vec[1];
    end
    grant_we    = we_vec[grant_idx];
    grant_addr  = addr_vec[grant_idx];
    grant_wdata = wdata_vec[grant_idx];
  end

  // The last ACCESS cycle is the one where the counter has run down to 0.
  logic last_access;
  assign last_access = (state_reg == ACCESS) && (cnt_reg == 4'd0);

  // -------------------------------------------------------------------------
  // Control FSM. All outputs are registered so RD/WR/ACK/BUSY change only on
  // clock edges. ADDR and DOUT are loaded at grant time and then simply hold,
  // which also keeps them stable outside ACCESS.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RES) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      last_reg  <= 1'b1;
      gnt_reg   <= 1'b0;
      we_reg    <= 1'b0;
      rd_reg    <= 1'b0;
      wr_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      ack_reg   <= 2'b00;
      addr_reg  <= 16'h0000;
      dout_reg  <= 16'h0000;
    end else begin
      case (state_reg)
        IDLE: begin
          ack_reg <= 2'b00;
          if (grant_any) begin
            state_reg <= ACCESS;
            cnt_reg   <= WAIT_LOAD;
            gnt_reg   <= grant_idx;
            last_reg  <= grant_idx;
            we_reg    <= grant_we;
            addr_reg  <= grant_addr;
            dout_reg  <= grant_wdata;
            rd_reg    <= ~grant_we;
            wr_reg    <= grant_we;
            busy_reg  <= 1'b1;
          end
        end

        ACCESS: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= DONE;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            ack_reg   <= gnt_reg ? 2'b10 : 2'b01;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end

        DONE: begin
          state_reg <= IDLE;
          ack_reg   <= 2'b00;
          busy_reg  <= 1'b0;
        end

        default: begin
          state_reg <= IDLE;
          rd_reg    <= 1'b0;
          wr_reg    <= 1'b0;
          ack_reg   <= 2'b00;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Per-port read data. DIN is captured on the last ACCESS cycle of a read
  // into the granted port only; the other port keeps its previous value.
  // A reset aborts a transaction before this point, so no partial update.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      localparam logic PORT_IDX = 1'(gi);
      logic [15:0] rdata_reg;

      always_ff @(posedge CLK) begin
        if (RES) begin
          rdata_reg <= 16'h0000;
        end else if (last_access && !we_reg && (gnt_reg == PORT_IDX)) begin
          rdata_reg <= DIN;
        end
      end

      assign rdata_vec[gi] = rdata_reg;
    end
  endgenerate

  assign ACK0   = ack_reg[0];
  assign ACK1   = ack_reg[1];
  assign RDATA0 = rdata_vec[0];
  assign RDATA1 = rdata_vec[1];
  assign RD     = rd_reg;
  assign WR     = wr_reg;
  assign ADDR   = addr_reg;
  assign DOUT   = dout_reg;
  assign BUSY   = busy_reg;
  assign GNT    = gnt_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Four arbiters with WAIT = 0..3 (instance index = WAIT) run side by side.
// A transaction-level model tracks, per instance, the active transaction and
// its age in cycles since the grant. From that age it derives every expected
// output. A single compare process checks all instances on each falling edge.
// Directed scenarios drive the instances in parallel; literal checks pin the
// model. A random phase follows.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

  localparam int NI = 4;

  logic        clk;
  logic        res    [NI];
  logic        req0   [NI];
  logic        req1   [NI];
  logic        we0    [NI];
  logic        we1    [NI];
  logic [15:0] addr0  [NI];
  logic [15:0] addr1  [NI];
  logic [15:0] wdata0 [NI];
  logic [15:0] wdata1 [NI];
  logic [15:0] din    [NI];
  logic        ack0   [NI];
  logic        ack1   [NI];
  logic [15:0] rdata0 [NI];
  logic [15:0] rdata1 [NI];
  logic        rd     [NI];
  logic        wr     [NI];
  logic [15:0] addr   [NI];
  logic [15:0] dout   [NI];
  logic        busy   [NI];
  logic        gnt    [NI];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      bus_arbiter #(.WAIT(gi)) u_dut (
        .CLK    (clk),
        .RES    (res[gi]),
        .REQ0   (req0[gi]),
        .REQ1   (req1[gi]),
        .WE0    (we0[gi]),
        .WE1    (we1[gi]),
        .ADDR0  (addr0[gi]),
        .ADDR1  (addr1[gi]),
        .WDATA0 (wdata0[gi]),
        .WDATA1 (wdata1[gi]),
        .ACK0   (ack0[gi]),
        .ACK1   (ack1[gi]),
        .RDATA0 (rdata0[gi]),
        .RDATA1 (rdata1[gi]),
        .RD     (rd[gi]),
        .WR     (wr[gi]),
        .ADDR   (addr[gi]),
        .DOUT   (dout[gi]),
        .DIN    (din[gi]),
        .BUSY   (busy[gi]),
        .GNT    (gnt[gi])
      );
    end
  endgenerate

  task automatic cmp(input string name, input int inst,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d cyc=%0d actual=%h required=%h",
               name, inst, cyc, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Transaction model. age counts cycles since the grant: ages 1..WAIT+1 are
  // the memory access, age WAIT+2 is the acknowledge, and after that the
  // instance is idle again.
  // -------------------------------------------------------------------------
  bit          m_valid  [NI];
  bit          m_active [NI];
  int          m_age    [NI];
  logic        m_port   [NI];
  logic        m_we     [NI];
  logic        m_last   [NI];
  logic        m_gnt    [NI];
  logic [15:0] m_addr   [NI];
  logic [15:0] m_wdata  [NI];
  logic [15:0] m_rdata0 [NI];
  logic [15:0] m_rdata1 [NI];

  initial begin
    for (int i = 0; i < NI; i++) m_valid[i] = 1'b0;
  end

  always @(posedge clk) begin : model_b
    logic p;
    for (int i = 0; i < NI; i++) begin
      if (res[i]) begin
        m_valid[i]  = 1'b1;
        m_active[i] = 1'b0;
        m_age[i]    = 0;
        m_last[i]   = 1'b1;
        m_gnt[i]    = 1'b0;
        m_rdata0[i] = 16'h0000;
        m_rdata1[i] = 16'h0000;
      end else if (!m_active[i]) begin
        if (req0[i] || req1[i]) begin
          p = (req0[i] && req1[i]) ? !m_last[i] : req1[i];
          m_active[i] = 1'b1;
          m_age[i]    = 1;
          m_port[i]   = p;
          m_last[i]   = p;
          m_gnt[i]    = p;
          m_we[i]     = p ? we1[i] : we0[i];
          m_addr[i]   = p ? addr1[i] : addr0[i];
          m_wdata[i]  = p ? wdata1[i] : wdata0[i];
        end
      end else if (m_age[i] == i + 2) begin
        m_active[i] = 1'b0;
      end else begin
        if (m_age[i] == i + 1 && !m_we[i]) begin
          if (m_port[i]) m_rdata1[i] = din[i];
          else           m_rdata0[i] = din[i];
        end
        m_age[i] = m_age[i] + 1;
      end
    end
  end

  always @(negedge clk) begin : compare_b
    logic e_rd, e_wr, e_ack0, e_ack1;
    for (int i = 0; i < NI; i++) begin
      if (m_valid[i]) begin
        e_rd   = m_active[i] && (m_age[i] <= i + 1) && !m_we[i];
        e_wr   = m_active[i] && (m_age[i] <= i + 1) && m_we[i];
        e_ack0 = m_active[i] && (m_age[i] == i + 2) && !m_port[i];
        e_ack1 = m_active[i] && (m_age[i] == i + 2) && m_port[i];
        cmp("rd", i, rd[i], e_rd);
        cmp("wr", i, wr[i], e_wr);
        cmp("ack0", i, ack0[i], e_ack0);
        cmp("ack1", i, ack1[i], e_ack1);
        cmp("busy", i, busy[i], m_active[i]);
        cmp("gnt", i, gnt[i], m_gnt[i]);
        cmp("rdata0", i, rdata0[i], m_rdata0[i]);
        cmp("rdata1", i, rdata1[i], m_rdata1[i]);
        if (e_rd || e_wr) cmp("addr", i, addr[i], m_addr[i]);
        if (e_wr)         cmp("dout", i, dout[i], m_wdata[i]);
        cmp("rd_wr_excl", i, rd[i] & wr[i], 1'b0);
        cmp("ack_excl", i, ack0[i] & ack1[i], 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus. Cycle c starts at the c-th tick after reset release; checks
  // read the outputs of cycle c, and then the inputs for cycle c are driven.
  // -------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < NI; i++) begin
      res[i] = 1'b1;  req0[i] = 1'b0;  req1[i] = 1'b0;
      we0[i] = 1'b0;  we1[i] = 1'b0;
      addr0[i] = 16'h0;  addr1[i] = 16'h0;
      wdata0[i] = 16'h0; wdata1[i] = 16'h0;
      din[i] = 16'h0;
    end
    repeat (3) tick();

    // Reset state.
    cmp("rst_busy", 1, busy[1], 1'b0);
    cmp("rst_rd", 1, rd[1], 1'b0);
    cmp("rst_wr", 1, wr[1], 1'b0);
    cmp("rst_gnt", 1, gnt[1], 1'b0);
    cmp("rst_ack0", 1, ack0[1], 1'b0);
    cmp("rst_addr", 1, addr[1], 16'h0000);
    cmp("rst_dout", 1, dout[1], 16'h0000);
    cmp("rst_rdata0", 1, rdata0[1], 16'h0000);

    for (int c = 0; c <= 34; c++) begin
      if (c > 0) tick();
      // Literal expectations for cycle c.
      case (c)
        1: begin
          cmp("w1_rd_c1", 1, rd[1], 1'b1);
          cmp("w1_addr_c1", 1, addr[1], 16'h0010);
          cmp("w1_busy_c1", 1, busy[1], 1'b1);
          cmp("w0_wr_c1", 0, wr[0], 1'b1);
          cmp("w0_rd_c1", 0, rd[0], 1'b0);
          cmp("w0_addr_c1", 0, addr[0], 16'h00F0);
          cmp("w0_dout_c1", 0, dout[0], 16'h1234);
        end
        2: begin
          cmp("w1_rd_c2", 1, rd[1], 1'b1);
          cmp("w1_ack0_c2", 1, ack0[1], 1'b0);
          cmp("w0_ack1_c2", 0, ack1[0], 1'b1);
          cmp("w0_wr_c2", 0, wr[0], 1'b0);
        end
        3: begin
          cmp("w1_ack0_c3", 1, ack0[1], 1'b1);
          cmp("w1_rd_c3", 1, rd[1], 1'b0);
          cmp("w1_busy_c3", 1, busy[1], 1'b1);
          cmp("w3_rd_after_rst", 3, rd[3], 1'b0);
          cmp("w3_busy_after_rst", 3, busy[3], 1'b0);
          cmp("w2_wr_c3", 2, wr[2], 1'b1);
        end
        4: begin
          cmp("w1_ack0_c4", 1, ack0[1], 1'b0);
          cmp("w1_rdata0_c4", 1, rdata0[1], 16'hBEEF);
          cmp("w1_busy_c4", 1, busy[1], 1'b0);
          cmp("w3_rdata0_c4", 3, rdata0[3], 16'h0000);
          cmp("w2_ack0_c4", 2, ack0[2], 1'b1);
        end
        6:  cmp("w1_busy_rst", 1, busy[1], 1'b0);
        9: begin
          cmp("w1_tie_ack0", 1, ack0[1], 1'b1);
          cmp("w1_tie_gnt0", 1, gnt[1], 1'b0);
          cmp("w3_ack0_c9", 3, ack0[3], 1'b0);
        end
        10: begin
          cmp("w3_ack0_c10", 3, ack0[3], 1'b1);
          cmp("w3_rdata0_c10", 3, rdata0[3], 16'h5555);
        end
        11: cmp("w1_gnt1_c11", 1, gnt[1], 1'b1);
        13: begin
          cmp("w1_ack1_c13", 1, ack1[1], 1'b1);
          cmp("w1_gnt1_c13", 1, gnt[1], 1'b1);
        end
        17: cmp("w1_alt_ack0_c17", 1, ack0[1], 1'b1);
        21: begin
          cmp("w1_alt_ack1_c21", 1, ack1[1], 1'b1);
          cmp("w1_alt_gnt_c21", 1, gnt[1], 1'b1);
        end
        25: cmp("w1_alt_ack0_c25", 1, ack0[1], 1'b1);
        29: cmp("w1_alt_ack1_c29", 1, ack1[1], 1'b1);
        33: cmp("w1_alt_ack0_c33", 1, ack0[1], 1'b1);
        default: ;
      endcase

      // Inputs for cycle c.
      case (c)
        0: begin
          for (int i = 0; i < NI; i++) res[i] = 1'b0;
          req0[1] = 1'b1; we0[1] = 1'b0; addr0[1] = 16'h0010; din[1] = 16'hBEEF;
          req1[0] = 1'b1; we1[0] = 1'b1; addr1[0] = 16'h00F0; wdata1[0] = 16'h1234;
          req0[3] = 1'b1; we0[3] = 1'b0; addr0[3] = 16'h0030; din[3] = 16'h5555;
          req0[2] = 1'b1; we0[2] = 1'b1; addr0[2] = 16'h0020; wdata0[2] = 16'hA5A5;
        end
        1: begin
          req1[0] = 1'b0; req0[1] = 1'b0; req0[2] = 1'b0; req0[3] = 1'b0;
        end
        2: res[3] = 1'b1;
        3: res[3] = 1'b0;
        5: begin
          res[1]  = 1'b1;
          req0[3] = 1'b1;
        end
        6: begin
          res[1]  = 1'b0;
          req0[1] = 1'b1; we0[1] = 1'b0; addr0[1] = 16'h0100; din[1] = 16'hCAFE;
          req1[1] = 1'b1; we1[1] = 1'b1; addr1[1] = 16'h0101; wdata1[1] = 16'h7777;
          req0[3] = 1'b0;
        end
        9:  req0[1] = 1'b0;
        13: req1[1] = 1'b0;
        14: begin
          req0[1] = 1'b1;
          req1[1] = 1'b1;
        end
        34: begin
          req0[1] = 1'b0;
          req1[1] = 1'b0;
        end
        default: ;
      endcase
    end

    // Random traffic on every instance, with occasional resets.
    for (int n = 0; n < 300; n++) begin
      tick();
      for (int i = 0; i < NI; i++) begin
        res[i]    = ($urandom_range(0, 49) == 0);
        req0[i]   = 1'($urandom_range(0, 1));
        req1[i]   = 1'($urandom_range(0, 1));
        we0[i]    = 1'($urandom_range(0, 1));
        we1[i]    = 1'($urandom_range(0, 1));
        addr0[i]  = 16'($urandom);
        addr1[i]  = 16'($urandom);
        wdata0[i] = 16'($urandom);
        wdata1[i] = 16'($urandom);
        din[i]    = 16'($urandom);
      end
    end

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter WAIT, default 1: number of extra memory wait cycles per access, legal range 0..15.
REQ-002 CLK  input  1  system clock; all state updates on its rising edge.
REQ-003 RES  input  1  reset, synchronous, active-high.
REQ-004 REQ0, REQ1  input  1 each  access request from requester 0 (core) and requester 1 (DMA/debug).
REQ-005 WE0, WE1  input  1 each  request type per port: 1 = write, 0 = read.
REQ-006 ADDR0, ADDR1  input  16 each  request address per port.
REQ-007 WDATA0, WDATA1  input  16 each  write data per port.
REQ-008 ACK0, ACK1  output  1 each  one-cycle completion strobe per port.
REQ-009 RDATA0, RDATA1  output  16 each  read data per port; holds its value until the next read completes on that port.
REQ-010 RD, WR  output  1 each  memory read and write strobes.
REQ-011 ADDR  output  16  memory address.
REQ-012 DOUT  output  16  memory write data.
REQ-013 DIN  input  16  memory read data.
REQ-014 BUSY  output  1  high whenever the state is not IDLE.
REQ-015 GNT  output  1  index of the port that owns the current transaction.

Function
REQ-016 The arbiter SHALL be an FSM with three states:
- IDLE
- ACCESS
- DONE
REQ-017 In IDLE, if any REQ is high, the arbiter SHALL grant one port:
- only one REQ high: grant that port;
- both high: grant the port not equal to LAST.
REQ-018 On a grant, the arbiter SHALL:
- latch WE, ADDR and WDATA of the granted port into internal registers;
- set GNT and LAST to the granted index;
- load the wait counter with WAIT;
- enter ACCESS.
REQ-019 In ACCESS, RD (read) or WR (write) SHALL be high, with ADDR and DOUT driven from the latched registers.
REQ-020 In ACCESS, the counter SHALL decrement each cycle; when it is 0, the FSM SHALL go to DONE, so ACCESS lasts exactly WAIT+1 cycles.
REQ-021 On the last ACCESS cycle of a read, DIN SHALL be registered into RDATA of the granted port.
REQ-022 In DONE, the arbiter SHALL:
- hold RD and WR low;
- hold ACK of the granted port high for exactly one cycle;
- move to IDLE on the next edge.
REQ-023 Latency from the IDLE cycle that sees REQ to the ACK cycle SHALL be WAIT+2 cycles; the total transaction is WAIT+3 cycles.
REQ-024 Port request signals SHALL be ignored outside IDLE; a REQ deasserted mid-transaction SHALL still see its access complete and be ACKed.
REQ-025 A REQ still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-026 RD and WR SHALL never be high simultaneously; at most one ACK SHALL be high in any cycle.
REQ-027 Fairness: with both REQs continuously high, grants SHALL alternate 0,1,0,1, and no port SHALL wait more than one full transaction.
REQ-028 Outside ACCESS, ADDR and DOUT SHALL hold their last values; ADDR and DOUT are don't-care when RD and WR are low.

Reset
REQ-029 While RES is high at a clock edge, the arbiter SHALL set:
- state IDLE;
- RD, WR, ACK0, ACK1, BUSY and GNT to 0;
- ADDR, DOUT, RDATA0 and RDATA1 to 0;
- LAST to 1, so port 0 wins the first tie;
- wait counter to 0.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction with no ACK and no RDATA update; RD and WR SHALL be low in the first cycle after the reset edge.
REQ-031 In the first cycle after RES deasserts, the FSM SHALL evaluate requests normally from IDLE.

Verification
REQ-032 WAIT=1, cycle 0: REQ0=1, WE0=0, ADDR0=0x0010, DIN=0xBEEF -> RD=1 with ADDR=0x0010 in cycles 1-2; ACK0=1 in cycle 3 only; RDATA0=0xBEEF from cycle 4; BUSY high in cycles 1-3.
REQ-033 WAIT=1, after reset, REQ0 and REQ1 both asserted in cycle 0 and each dropped after its ACK -> port 0 served first (ACK0 in cycle 3); port 1 granted in cycle 4 (ACK1 in cycle 7, GNT=1 during cycles 5-7).
REQ-034 WAIT=0, REQ1=1, WE1=1, ADDR1=0x00F0, WDATA1=0x1234 -> WR=1 for exactly one cycle with ADDR=0x00F0 and DOUT=0x1234; ACK1 in the next cycle; RD never high.
REQ-035 WAIT=1, REQ0 and REQ1 held high for 20 cycles -> ACKs alternate ACK0, ACK1, ACK0 ... every 4 cycles; RD/WR and ACK mutual-exclusion assertions hold throughout.
REQ-036 WAIT=3, read started in cycle 0, RES pulsed high in cycle 2 -> RD=0 from cycle 3; no ACK0; RDATA0=0; a new REQ0 after reset completes normally with ACK0 five cycles after it is sampled in IDLE.
REQ-037 WAIT=2, REQ0 dropped in cycle 1 during ACCESS -> access still completes and ACK0 is high in cycle 4.
